// File: rtl/systolic_feeder_3by3_if.sv
// Load port of the systolic feeder: valid/ready element write channel.
interface systolic_feeder_3by3_if #(
    parameter int DW = 8
);
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/systolic_feeder_3by3.sv
// Operand buffer and diagonally skewed A-row / B-column streamer for an NxN systolic array.
// Optional array clear before streaming is enabled by defining FEEDER_CLR_EN.
module systolic_feeder_3by3 #(
    parameter int N            = 3,
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    systolic_feeder_3by3_if.slave  load,
    input  logic                   start,
    output logic                   busy,
    output logic                   array_clr,
    output logic [N*DW-1:0]        a_out,
    output logic [N*DW-1:0]        b_out,
    output logic                   valid_out,
    output logic                   done
);
    localparam int TOTAL = 2 * N * N;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(TOTAL);

    localparam logic [CW-1:0] TOTAL_C    = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_STEP  = CW'(2 * N - 2);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYCLES - 1);

`ifdef FEEDER_CLR_EN
    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, DONE} state_t;
`endif

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [CW-1:0] ld_cnt;
    logic          ready;
    logic          load_fire;
    logic [DW-1:0] buf_mem [TOTAL];

    assign ready          = (state == IDLE) && (ld_cnt < TOTAL_C);
    assign load.load_ready = ready;
    assign load_fire      = load.load_valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ld_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load_fire)
                ld_cnt <= ld_cnt + CW'(1);
            else if (state == DONE)
                ld_cnt <= '0;
        end
    end

    // Buffer contents survive reset; only the fill count is cleared.
    always_ff @(posedge clk) begin
        if (!reset && load_fire)
            buf_mem[AW'(ld_cnt)] <= load.load_data;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        array_clr  = 1'b0;
        valid_out  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                // Count is sampled before this edge, so a load finishing now does not qualify.
                if (start && ld_cnt == TOTAL_C) begin
                    cnt_next = '0;
`ifdef FEEDER_CLR_EN
                    state_next = CLR;
`else
                    state_next = STREAM;
`endif
                end
            end
`ifdef FEEDER_CLR_EN
            CLR: begin
                busy       = 1'b1;
                array_clr  = 1'b1;
                state_next = STREAM;
            end
`endif
            STREAM: begin
                busy      = 1'b1;
                valid_out = 1'b1;
                if (cnt == LAST_STEP) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt == LAST_DRAIN) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Row i lags by i steps (A[i][t-i]); column j lags by j steps (B[t-j][j]).
    always_comb begin
        int ai;
        int bj;
        ai    = 0;
        bj    = 0;
        a_out = '0;
        b_out = '0;
        if (state == STREAM) begin
            for (int unsigned i = 0; i < N; i++) begin
                ai = int'(cnt) - int'(i);
                if (ai >= 0 && ai < N)
                    a_out[i*DW +: DW] = buf_mem[AW'(int'(i) * N + ai)];
                bj = int'(cnt) - int'(i);
                if (bj >= 0 && bj < N)
                    b_out[i*DW +: DW] = buf_mem[AW'(N * N + bj * N + int'(i))];
            end
        end
    end
endmodule

// File: tb/tb_systolic_feeder_3by3.sv
// Directed self-checking bench for systolic_feeder_3by3 (N=3, DW=8, DRAIN_CYCLES=4).
module tb_systolic_feeder_3by3;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        array_clr;
    logic [23:0] a_out;
    logic [23:0] b_out;
    logic        valid_out;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  elem    [18] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    logic [23:0] exp_a   [5]  = '{24'h000001, 24'h000402, 24'h070503, 24'h080600, 24'h090000};
    logic [23:0] exp_b   [5]  = '{24'h000009, 24'h000806, 24'h070503, 24'h040200, 24'h010000};
    int          exp_c   [9]  = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    int acc [3][3];
    int ar  [3][3];
    int br  [3][3];

    systolic_feeder_3by3_if #(.DW(8)) lif ();

    systolic_feeder_3by3 #(.N(3), .DW(8), .DRAIN_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (lif),
        .start     (start),
        .busy      (busy),
        .array_clr (array_clr),
        .a_out     (a_out),
        .b_out     (b_out),
        .valid_out (valid_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(valid_out), 64'd0);
        check({tag, "_clr"},   64'(array_clr), 64'd0);
        check({tag, "_a"},     64'(a_out), 64'd0);
        check({tag, "_b"},     64'(b_out), 64'd0);
    endtask

    task automatic load_elems(input int first, input int count, input bit gaps);
        for (int k = first; k < first + count; k++) begin
            if (gaps && (k % 3 == 1)) begin
                lif.load_valid = 1'b0;
                lif.load_data  = 8'hAA;
                tick();
            end
            lif.load_valid = 1'b1;
            lif.load_data  = elem[k];
            tick();
        end
        lif.load_valid = 1'b0;
        lif.load_data  = 8'h00;
    endtask

    // Output-stationary 3x3 array: a moves right, b moves down, one hop per cycle.
    task automatic model_clear();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                acc[i][j] = 0;
                ar[i][j]  = 0;
                br[i][j]  = 0;
            end
    endtask

    task automatic model_step();
        int na [3][3];
        int nb [3][3];
        logic [23:0] av;
        logic [23:0] bv;
        av = a_out;
        bv = b_out;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                na[i][j] = (j == 0) ? int'(av[i*8 +: 8]) : ar[i][j-1];
                nb[i][j] = (i == 0) ? int'(bv[j*8 +: 8]) : br[i-1][j];
                acc[i][j] += na[i][j] * nb[i][j];
            end
        ar = na;
        br = nb;
    endtask

    task automatic run_stream(input bit hold_valid);
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FEEDER_CLR_EN
        check("clr_pulse", 64'(array_clr), 64'd1);
        check("clr_valid", 64'(valid_out), 64'd0);
        check("clr_busy",  64'(busy), 64'd1);
        check("clr_a",     64'(a_out), 64'd0);
        tick();
`endif
        model_clear();
        for (int t = 0; t < 5; t++) begin
            if (hold_valid) begin
                lif.load_valid = 1'b1;
                lif.load_data  = 8'hEE;
            end
            check($sformatf("t%0d_valid", t), 64'(valid_out), 64'd1);
            check($sformatf("t%0d_clr", t),   64'(array_clr), 64'd0);
            check($sformatf("t%0d_busy", t),  64'(busy), 64'd1);
            check($sformatf("t%0d_ready", t), 64'(lif.load_ready), 64'd0);
            check($sformatf("t%0d_a", t),     64'(a_out), 64'(exp_a[t]));
            check($sformatf("t%0d_b", t),     64'(b_out), 64'(exp_b[t]));
            model_step();
            tick();
        end
        lif.load_valid = 1'b0;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("drain%0d_valid", d), 64'(valid_out), 64'd0);
            check($sformatf("drain%0d_busy", d),  64'(busy), 64'd1);
            check($sformatf("drain%0d_done", d),  64'(done), 64'd0);
            check($sformatf("drain%0d_ab", d),    64'({a_out, b_out}), 64'd0);
            model_step();
            tick();
        end
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy",  64'(busy), 64'd0);
        tick();
        check("done_once",  64'(done), 64'd0);
        check("post_ready", 64'(lif.load_ready), 64'd1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("c%0d%0d", i, j), 64'(acc[i][j]), 64'(exp_c[i*3+j]));
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and full load
        check_idle("rst");
        check("rst_done",  64'(done), 64'd0);
        check("rst_ready", 64'(lif.load_ready), 64'd1);
        load_elems(0, 17, 1'b0);
        check("ld17_ready", 64'(lif.load_ready), 64'd1);
        load_elems(17, 1, 1'b0);
        check("ld18_ready", 64'(lif.load_ready), 64'd0);
        tick();
        check_idle("loaded");

        // Normal run
        run_stream(1'b0);

        // Partial load: start ignored; completion coinciding with start also ignored
        load_elems(0, 10, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_idle($sformatf("part%0d", c));
            check($sformatf("part%0d_ready", c), 64'(lif.load_ready), 64'd1);
            tick();
        end
        load_elems(10, 7, 1'b0);
        lif.load_valid = 1'b1;
        lif.load_data  = elem[17];
        start          = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        start          = 1'b0;
        check_idle("same_cycle");
        check("same_cycle_ready", 64'(lif.load_ready), 64'd0);
        tick();
        check("same_cycle_busy2", 64'(busy), 64'd0);
        run_stream(1'b0);

        // Gapped load, load_valid held while streaming
        load_elems(0, 18, 1'b1);
        check("gap_ready", 64'(lif.load_ready), 64'd0);
        run_stream(1'b1);

        // Reset during STREAM t2
        load_elems(0, 18, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FEEDER_CLR_EN
        tick();
`endif
        check("abort_t0_a", 64'(a_out), 64'(exp_a[0]));
        tick();
        tick();
        check("abort_t2_a", 64'(a_out), 64'(exp_a[2]));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        check("abort_ready", 64'(lif.load_ready), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_idle($sformatf("noreload%0d", c));
            tick();
        end
        load_elems(0, 17, 1'b0);
        check("reload17_ready", 64'(lif.load_ready), 64'd1);
        load_elems(17, 1, 1'b0);
        check("reload18_ready", 64'(lif.load_ready), 64'd0);
        run_stream(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
